instr_fetch_unit: RTL and testbench

Fetch-side initiator for the instruction memory port. It generates word-aligned fetch addresses and issues in-order read requests over a valid/ready request channel. It collects in-order responses into a prefetch FIFO and presents {pc, instr} to decode with a valid/ready handshake. Branch redirects flush the FIFO and squash in-flight responses.

---
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit,
// buffers in-order responses in a small prefetch FIFO, and flushes on branch redirects.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);
    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CNT_W-1:0]  inflight_reg, inflight_next;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;

    logic [ADDR_W-1:0] fifo_pc_mem    [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_instr_mem [FIFO_DEPTH];

    logic [CNT_W-1:0]  inflight_live;
    logic [CNT_W:0]    credit_used;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              req_fire;
    logic              push;
    logic              pop;

    // Every request holds a credit until its data leaves the FIFO, so a live
    // response always finds a free slot and responses need no backpressure.
    assign inflight_live  = inflight_reg - drop_cnt_reg;
    assign credit_used    = {1'b0, count_reg} + {1'b0, inflight_live};
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign redirect_tgt   = redirect_pc & WORD_MASK;

    assign if_valid = (count_reg != '0);
    assign if_pc    = if_valid ? fifo_pc_mem[rd_ptr_reg]    : '0;
    assign if_instr = if_valid ? fifo_instr_mem[rd_ptr_reg] : '0;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        inflight_next = inflight_reg;
        drop_cnt_next = drop_cnt_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        push          = 1'b0;
        pop           = 1'b0;

        if (req_fire && !imem_rsp_valid) begin
            inflight_next = inflight_reg + CNT_ONE;
        end else if (!req_fire && imem_rsp_valid) begin
            inflight_next = inflight_reg - CNT_ONE;
        end

        if (redirect_valid) begin
            // No request is issued this cycle, so everything still outstanding
            // after this cycle's response is stale and must be discarded.
            fetch_pc_next = redirect_tgt;
            rsp_pc_next   = redirect_tgt;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            drop_cnt_next = inflight_next;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_reg != '0) begin
                    drop_cnt_next = drop_cnt_reg - CNT_ONE;
                end else begin
                    push        = 1'b1;
                    rsp_pc_next = rsp_pc_reg + PC_STEP;
                end
            end
            pop = if_valid && if_ready;
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (!push && pop) begin
                count_next = count_reg - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Storage needs no reset: the head is masked by if_valid whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
            fifo_instr_mem[wr_ptr_reg] <= imem_rsp_data;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (inflight_reg != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> ((count_reg != CNT_FULL) || pop));
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural memory with configurable latency, a
// request-time scoreboard of {pc, instr}, a redirect-alignment table and corner sequences.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    int checks = 0;
    int failures = 0;
    int mem_lat = 1;
    int cyc = 0;
    int req_cnt = 0;
    logic [31:0] mem [64];

    typedef struct { logic [31:0] data; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] target; logic [31:0] want_addr; } redir_vec_t;
    pend_t       pend_q[$];
    exp_t        exp_q[$];
    exp_t        sb_e;
    logic [31:0] delivered[$];
    redir_vec_t  redir_tab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_delivered(input int n, input int budget, input string name);
        int k = 0;
        while (delivered.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (delivered.size() < n) begin
            failures++;
            $display("FAIL %s timeout delivered=%0d required=%0d", name, delivered.size(), n);
        end
    endtask

    function automatic logic [31:0] dlv(input int i);
        return (i < delivered.size()) ? delivered[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset(input int lat, input logic rdy, input logic irdy);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = rdy;
        if_ready = irdy;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        delivered.delete();
        req_cnt = 0;
    endtask

    // Memory: in-order, fixed latency, cleared by reset.
    always @(posedge clk) begin
        if (!rst_n) pend_q.delete();
        else if (imem_req_valid && imem_req_ready)
            pend_q.push_back('{mem[imem_req_addr[7:2]], cyc + mem_lat});
        cyc++;
        #1;
        if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_q[0].data;
            void'(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard: expectation queued at request acceptance, retired at decode pop.
    always @(negedge clk) begin
        if (!rst_n || redirect_valid) begin
            exp_q.delete();
        end else begin
            if (if_valid && if_ready) begin
                delivered.push_back(if_pc);
                $display("deliver pc=%h instr=%h", if_pc, if_instr);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected pc=%h instr=%h required=no_delivery", if_pc, if_instr);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_pc", if_pc, sb_e.pc);
                    chk("sb_instr", if_instr, sb_e.instr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back('{imem_req_addr, mem[imem_req_addr[7:2]]});
                req_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
        mem[0] = 32'hE680_100A;
        mem[1] = 32'hE680_2014;
        mem[2] = 32'hE021_3000;
        redir_tab[0] = '{32'h0000_0040, 32'h0000_0040};
        redir_tab[1] = '{32'h0000_001E, 32'h0000_001C};
        redir_tab[2] = '{32'h0000_0003, 32'h0000_0000};
        redir_tab[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        redir_tab[4] = '{32'h0000_0101, 32'h0000_0100};

        // 1: reset values, first-fetch latency, steady stream
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        delivered.delete();
        @(negedge clk);
        chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req_addr0", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t1_if_valid_c1", {31'b0, if_valid}, 32'd0);
        chk("t1_req_addr1", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("t1_if_valid_c2", {31'b0, if_valid}, 32'd1);
        chk("t1_pc0", if_pc, 32'h0);
        chk("t1_instr0", if_instr, 32'hE680_100A);
        @(negedge clk);
        chk("t1_pc1", if_pc, 32'h4);
        chk("t1_instr1", if_instr, 32'hE680_2014);
        @(negedge clk);
        chk("t1_pc2", if_pc, 32'h8);
        chk("t1_instr2", if_instr, 32'hE021_3000);

        // 2: decode stall caps outstanding work at FIFO_DEPTH
        do_reset(1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("t2_req_count", req_cnt, 32'd4);
        chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t2_head_pc", if_pc, 32'h0);
        @(posedge clk); #1;
        if_ready = 1'b1;
        wait_delivered(6, 30, "t2_drain");
        chk("t2_pc3", dlv(3), 32'hC);
        chk("t2_resume_pc", dlv(4), 32'h10);

        // 3: redirect with two stale requests in flight on a slow memory
        do_reset(3, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        chk("t3_redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h40);
        wait_delivered(3, 40, "t3_deliver");
        chk("t3_first_pc", dlv(0), 32'h40);
        bad = 0;
        for (int i = 0; i < delivered.size(); i++)
            if (delivered[i] == 32'h4 || delivered[i] == 32'h8) bad++;
        chk("t3_no_stale", bad, 32'd0);

        // 4a: redirect target alignment table
        do_reset(1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            redirect_valid = 1'b1;
            redirect_pc = redir_tab[i].target;
            @(negedge clk);
            chk("t4_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            @(negedge clk);
            chk("t4_next_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("t4_next_addr", imem_req_addr, redir_tab[i].want_addr);
        end

        // 4b: redirect coinciding with a response and a pop
        do_reset(1, 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        chk("t4b_fifo_busy", {31'b0, if_valid}, 32'd1);
        chk("t4b_no_req", {31'b0, imem_req_valid}, 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        delivered.delete();
        @(negedge clk);
        chk("t4b_if_valid", {31'b0, if_valid}, 32'd0);
        chk("t4b_if_pc", if_pc, 32'h0);
        chk("t4b_if_instr", if_instr, 32'h0);
        chk("t4b_req_addr", imem_req_addr, 32'h80);
        wait_delivered(2, 20, "t4b_deliver");
        chk("t4b_pc0", dlv(0), 32'h80);
        chk("t4b_pc1", dlv(1), 32'h84);

        // 5: request hold under memory stall, then fetch_pc wrap
        do_reset(1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("t5_hold_addr", imem_req_addr, 32'h0);
        end
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("t5_advance_addr", imem_req_addr, 32'h4);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        imem_req_ready = 1'b1;
        delivered.delete();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_wrap_addr", imem_req_addr, 32'h0);
        wait_delivered(2, 20, "t5_deliver");
        chk("t5_pc_top", dlv(0), 32'hFFFF_FFFC);
        chk("t5_pc_wrap", dlv(1), 32'h0);

        // 6: asynchronous reset with FIFO at 3 and one request in flight
        do_reset(1, 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        chk("t6_pre_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t6_pre_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t6_rst_if_pc", if_pc, 32'h0);
        chk("t6_rst_addr", imem_req_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        if_ready = 1'b1;
        delivered.delete();
        wait_delivered(2, 20, "t6_deliver");
        chk("t6_pc0", dlv(0), 32'h0);
        chk("t6_pc1", dlv(1), 32'h4);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
